// File: rtl/decode_pkg.sv
// Shared types and defaults for the decode (ID) stage and its ID/EX register.
package decode_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned REG_AW_DEF    = 5;
  localparam int unsigned ALUCTRL_W_DEF = 3;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef struct packed {
    logic                     reg_write;
    logic                     alu_src;
    logic                     mem_write;
    logic                     result_src;
    logic                     branch;
    logic [ALUCTRL_W_DEF-1:0] alu_control;
  } ctrl_e_t;

  localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/Control_Unit_Top.sv
// Main + ALU decoder for the RV32I subset: lw, sw, R-type, I-type ALU, beq.
module Control_Unit_Top (
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic       ALUSrc,
  output logic       MemWrite,
  output logic       ResultSrc,
  output logic       Branch,
  output logic [2:0] ALUControl
);

  logic [1:0] alu_op;

  always_comb begin
    RegWrite  = 1'b0;
    ImmSrc    = 2'b00;
    ALUSrc    = 1'b0;
    MemWrite  = 1'b0;
    ResultSrc = 1'b0;
    Branch    = 1'b0;
    alu_op    = 2'b00;
    case (Op)
      7'b0000011: begin RegWrite = 1'b1; ALUSrc = 1'b1; ResultSrc = 1'b1; end
      7'b0100011: begin ImmSrc = 2'b01; ALUSrc = 1'b1; MemWrite = 1'b1; end
      7'b0110011: begin RegWrite = 1'b1; alu_op = 2'b10; end
      7'b0010011: begin RegWrite = 1'b1; ALUSrc = 1'b1; alu_op = 2'b10; end
      7'b1100011: begin ImmSrc = 2'b10; Branch = 1'b1; alu_op = 2'b01; end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          // Only R-type (Op[5]=1) with funct7[5] is a subtract; addi ignores bit 30.
          3'b000:  ALUControl = (Op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: rtl/Sign_Extend.sv
// Immediate generator: I, S, B and J formats, sign-extended to 32 bits.
module Sign_Extend (
  input  logic [31:7] In,
  input  logic [1:0]  ImmSrc,
  output logic [31:0] Imm_Ext
);

  always_comb begin
    case (ImmSrc)
      2'b00:   Imm_Ext = {{20{In[31]}}, In[31:20]};
      2'b01:   Imm_Ext = {{20{In[31]}}, In[31:25], In[11:7]};
      2'b10:   Imm_Ext = {{19{In[31]}}, In[31], In[7], In[30:25], In[11:8], 1'b0};
      default: Imm_Ext = {{11{In[31]}}, In[31], In[19:12], In[20], In[30:21], 1'b0};
    endcase
  end

endmodule

// File: rtl/decode_regfile.sv
// NREGS x XLEN register file, 2 read / 1 write, x0 reads as zero.
// DECODE_WB_BYPASS_EN: same-cycle writeback data is forwarded to the read ports.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            wr_en;

  assign wr_en = we && (waddr != '0) && (32'(waddr) < NREGS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [REG_AW-1:0] a);
    logic [XLEN-1:0] r;
    r = '0;
    if ((a != '0) && (32'(a) < NREGS)) begin
      r = mem_q[a];
`ifdef DECODE_WB_BYPASS_EN
      if (we && (waddr == a)) r = wdata;
`endif
    end
    return r;
  endfunction

  always_comb rdata1 = read_port(raddr1);
  always_comb rdata2 = read_port(raddr2);

endmodule

// File: rtl/decode_stage_hz.sv
// ID stage with ID/EX register, load-use stall and bubble insertion.
// Optional DECODE_WB_BYPASS_EN enables write-first forwarding in the register file.
module decode_stage_hz
  import decode_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned REG_AW    = REG_AW_DEF,
  parameter int unsigned ALUCTRL_W = ALUCTRL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          InstrD,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic                 ValidD,
  input  logic                 RegWriteW,
  input  logic [REG_AW-1:0]    RDW,
  input  logic [XLEN-1:0]      ResultW,
  input  logic                 FlushE,
  output logic                 StallD,
  output logic                 ValidE,
  output logic                 RegWriteE,
  output logic                 ALUSrcE,
  output logic                 MemWriteE,
  output logic                 ResultSrcE,
  output logic                 BranchE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic [XLEN-1:0]      RD1_E,
  output logic [XLEN-1:0]      RD2_E,
  output logic [XLEN-1:0]      Imm_Ext_E,
  output logic [REG_AW-1:0]    RS1_E,
  output logic [REG_AW-1:0]    RS2_E,
  output logic [REG_AW-1:0]    RD_E,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      PCPlus4E
);

  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
  logic [1:0]        imm_src_d;
  logic [31:0]       imm32_d;
  logic [XLEN-1:0]   imm_d, rd1_d, rd2_d;
  ctrl_e_t           ctrl_dec, ctrl_d, ctrl_q;
  logic              valid_d, valid_q, load_use;
  logic [XLEN-1:0]   rd1_n, rd2_n, imm_n, pc_n, pc4_n;
  logic [XLEN-1:0]   rd1_q, rd2_q, imm_q, pc_q, pc4_q;
  logic [REG_AW-1:0] rs1_n, rs2_n, rd_n, rs1_q, rs2_q, rd_q;

  assign rs1_d = REG_AW'(InstrD[19:15]);
  assign rs2_d = REG_AW'(InstrD[24:20]);
  assign rd_d  = REG_AW'(InstrD[11:7]);

  Control_Unit_Top u_ctrl (
    .Op         (InstrD[6:0]),
    .funct3     (InstrD[14:12]),
    .funct7b5   (InstrD[30]),
    .RegWrite   (ctrl_dec.reg_write),
    .ImmSrc     (imm_src_d),
    .ALUSrc     (ctrl_dec.alu_src),
    .MemWrite   (ctrl_dec.mem_write),
    .ResultSrc  (ctrl_dec.result_src),
    .Branch     (ctrl_dec.branch),
    .ALUControl (ctrl_dec.alu_control)
  );

  Sign_Extend u_sext (
    .In      (InstrD[31:7]),
    .ImmSrc  (imm_src_d),
    .Imm_Ext (imm32_d)
  );

  assign imm_d = XLEN'($signed(imm32_d));

  decode_regfile #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWriteW),
    .waddr  (RDW),
    .wdata  (ResultW),
    .raddr1 (rs1_d),
    .raddr2 (rs2_d),
    .rdata1 (rd1_d),
    .rdata2 (rd2_d)
  );

  // A load in EX whose destination is read by the instruction in ID must wait one cycle.
  assign load_use = valid_q && ctrl_q.result_src && ctrl_q.reg_write && (rd_q != '0) &&
                    ValidD && ((rd_q == rs1_d) || (rd_q == rs2_d));
  assign StallD   = load_use && !FlushE;

  always_comb begin
    valid_d = 1'b0;
    ctrl_d  = CTRL_BUBBLE;
    rd1_n   = '0;
    rd2_n   = '0;
    imm_n   = '0;
    rs1_n   = '0;
    rs2_n   = '0;
    rd_n    = '0;
    pc_n    = '0;
    pc4_n   = '0;
    if (!FlushE && !load_use && ValidD) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_dec;
      rd1_n   = rd1_d;
      rd2_n   = rd2_d;
      imm_n   = imm_d;
      rs1_n   = rs1_d;
      rs2_n   = rs2_d;
      rd_n    = rd_d;
      pc_n    = PCD;
      pc4_n   = PCPlus4D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rd1_q   <= rd1_n;
      rd2_q   <= rd2_n;
      imm_q   <= imm_n;
      rs1_q   <= rs1_n;
      rs2_q   <= rs2_n;
      rd_q    <= rd_n;
      pc_q    <= pc_n;
      pc4_q   <= pc4_n;
    end
  end

  assign ValidE      = valid_q;
  assign RegWriteE   = ctrl_q.reg_write;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign MemWriteE   = ctrl_q.mem_write;
  assign ResultSrcE  = ctrl_q.result_src;
  assign BranchE     = ctrl_q.branch;
  assign ALUControlE = ALUCTRL_W'(ctrl_q.alu_control);
  assign RD1_E       = rd1_q;
  assign RD2_E       = rd2_q;
  assign Imm_Ext_E   = imm_q;
  assign RS1_E       = rs1_q;
  assign RS2_E       = rs2_q;
  assign RD_E        = rd_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc4_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Scoreboard bench for decode_stage_hz: directed instructions, expected ID/EX contents queued.
module tb_decode_stage_hz;

  typedef struct {
    logic        valid;
    logic [7:0]  ctrl;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, pc4;
  } exp_t;

  localparam logic [7:0] C_ADD  = 8'h80;
  localparam logic [7:0] C_LW   = 8'hD0;
  localparam logic [7:0] C_ADDI = 8'hC0;
  localparam logic [7:0] C_SW   = 8'h60;
`ifdef DECODE_WB_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'h12345678;
`else
  localparam logic [31:0] BYP_EXP = 32'h00000001;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        ValidD = 1'b0, RegWriteW = 1'b0, FlushE = 1'b0;
  logic [4:0]  RDW = '0;
  logic        StallD, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RS1_E, RS2_E, RD_E;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] pc = 32'h1000;

  decode_stage_hz dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE), .StallD(StallD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE), .RD1_E(RD1_E),
    .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t bub();
    exp_t e;
    e.valid = 1'b0; e.ctrl = '0; e.rd1 = '0; e.rd2 = '0; e.imm = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.pc = '0; e.pc4 = '0;
    return e;
  endfunction

  function automatic exp_t ex(input logic [7:0] c, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] im, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d);
    exp_t e;
    e = bub();
    e.valid = 1'b1; e.ctrl = c; e.rd1 = r1; e.rd2 = r2; e.imm = im;
    e.rs1 = s1; e.rs2 = s2; e.rd = d;
    return e;
  endfunction

  function automatic logic [31:0] f_r(input logic [4:0] d, input logic [4:0] s1,
                                      input logic [4:0] s2);
    return {7'b0, s2, s1, 3'b000, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] f_lw(input logic [4:0] d, input logic [4:0] s1,
                                       input logic [11:0] im);
    return {im, s1, 3'b010, d, 7'b0000011};
  endfunction

  // Drive one ID cycle on the negedge and queue what ID/EX must hold after the next posedge.
  task automatic step(input logic [31:0] instr, input logic vd, input logic rw,
                      input logic [4:0] rdw, input logic [31:0] res, input logic flush,
                      input logic adv, input logic exp_stall, input exp_t e);
    @(negedge clk);
    if (adv) pc = pc + 32'd4;
    InstrD = instr; ValidD = vd; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = rw; RDW = rdw; ResultW = res; FlushE = flush;
    if (e.valid) begin
      e.pc  = pc;
      e.pc4 = pc + 32'd4;
    end
    exp_q.push_back(e);
    #1 chk("stall_d", {63'd0, StallD}, {63'd0, exp_stall});
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    step(32'h0, 1'b0, 1'b1, r, v, 1'b0, 1'b0, 1'b0, bub());
  endtask

  task automatic dec(input logic [31:0] instr, input logic stall, input exp_t e);
    step(instr, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, stall, e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {63'd0, ValidE}, 64'd0);
    chk({tag, "_ctrl"},
        {56'd0, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE}, 64'd0);
    chk({tag, "_rd1"}, {32'd0, RD1_E}, 64'd0);
    chk({tag, "_rd2"}, {32'd0, RD2_E}, 64'd0);
    chk({tag, "_imm"}, {32'd0, Imm_Ext_E}, 64'd0);
    chk({tag, "_idx"}, {49'd0, RS1_E, RS2_E, RD_E}, 64'd0);
    chk({tag, "_pc"}, {PCE, PCPlus4E}, 64'd0);
    chk({tag, "_stall"}, {63'd0, StallD}, 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("valid_e", {63'd0, ValidE}, {63'd0, mon_e.valid});
      chk("ctrl_e", {56'd0, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE},
          {56'd0, mon_e.ctrl});
      chk("rd1_e", {32'd0, RD1_E}, {32'd0, mon_e.rd1});
      chk("rd2_e", {32'd0, RD2_E}, {32'd0, mon_e.rd2});
      chk("imm_e", {32'd0, Imm_Ext_E}, {32'd0, mon_e.imm});
      chk("rs1_e", {59'd0, RS1_E}, {59'd0, mon_e.rs1});
      chk("rs2_e", {59'd0, RS2_E}, {59'd0, mon_e.rs2});
      chk("rd_e", {59'd0, RD_E}, {59'd0, mon_e.rd});
      chk("pc_e", {PCE, PCPlus4E}, {mon_e.pc, mon_e.pc4});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12 chk_all_zero("rst_init");
    @(negedge clk) rst = 1'b1;

    // Reset mid-operation clears ID/EX at once and empties the register file.
    wb(5'd5, 32'hAAAA5555);
    dec(f_r(5'd6, 5'd5, 5'd0), 1'b0, ex(C_ADD, 32'hAAAA5555, 0, 0, 5'd5, 5'd0, 5'd6));
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge clk) rst = 1'b1;
    dec(f_r(5'd6, 5'd5, 5'd0), 1'b0, ex(C_ADD, 0, 0, 0, 5'd5, 5'd0, 5'd6));

    // Plain read, and x0 stays zero after an attempted write.
    wb(5'd5, 32'hDEADBEEF);
    step(f_r(5'd6, 5'd5, 5'd0), 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0,
         ex(C_ADD, 32'hDEADBEEF, 0, 0, 5'd5, 5'd0, 5'd6));
    dec(f_r(5'd1, 5'd0, 5'd0), 1'b0, ex(C_ADD, 0, 0, 0, 5'd0, 5'd0, 5'd1));

    // Same-cycle writeback and read of x7.
    wb(5'd7, 32'h1);
    step(f_r(5'd8, 5'd7, 5'd0), 1'b1, 1'b1, 5'd7, 32'h12345678, 1'b0, 1'b1, 1'b0,
         ex(C_ADD, BYP_EXP, 0, 0, 5'd7, 5'd0, 5'd8));
    dec(f_r(5'd8, 5'd7, 5'd0), 1'b0, ex(C_ADD, 32'h12345678, 0, 0, 5'd7, 5'd0, 5'd8));

    // Load-use on rs1: one bubble, then the held add is captured.
    wb(5'd1, 32'h100);
    wb(5'd2, 32'h22);
    wb(5'd3, 32'h33);
    dec(f_lw(5'd3, 5'd1, 12'd0), 1'b0, ex(C_LW, 32'h100, 0, 0, 5'd1, 5'd0, 5'd3));
    dec(f_r(5'd4, 5'd3, 5'd2), 1'b1, bub());
    step(f_r(5'd4, 5'd3, 5'd2), 1'b1, 1'b0, 5'd0, 0, 1'b0, 1'b0, 1'b0,
         ex(C_ADD, 32'h33, 32'h22, 32'd2, 5'd3, 5'd2, 5'd4));

    // Flush wins over load-use.
    dec(f_lw(5'd3, 5'd1, 12'd0), 1'b0, ex(C_LW, 32'h100, 0, 0, 5'd1, 5'd0, 5'd3));
    step(f_r(5'd4, 5'd3, 5'd2), 1'b1, 1'b0, 5'd0, 0, 1'b1, 1'b1, 1'b0, bub());

    // Invalid ID slot never stalls.
    dec(f_lw(5'd3, 5'd1, 12'd0), 1'b0, ex(C_LW, 32'h100, 0, 0, 5'd1, 5'd0, 5'd3));
    step(f_r(5'd4, 5'd3, 5'd2), 1'b0, 1'b0, 5'd0, 0, 1'b0, 1'b1, 1'b0, bub());

    // Load-use through rs2.
    dec(f_lw(5'd3, 5'd1, 12'd0), 1'b0, ex(C_LW, 32'h100, 0, 0, 5'd1, 5'd0, 5'd3));
    dec(f_r(5'd4, 5'd2, 5'd3), 1'b1, bub());
    step(f_r(5'd4, 5'd2, 5'd3), 1'b1, 1'b0, 5'd0, 0, 1'b0, 1'b0, 1'b0,
         ex(C_ADD, 32'h22, 32'h33, 32'd3, 5'd2, 5'd3, 5'd4));

    // Load into x0 creates no hazard.
    dec(f_lw(5'd0, 5'd1, 12'd0), 1'b0, ex(C_LW, 32'h100, 0, 0, 5'd1, 5'd0, 5'd0));
    dec(f_r(5'd4, 5'd0, 5'd0), 1'b0, ex(C_ADD, 0, 0, 0, 5'd0, 5'd0, 5'd4));

    // addi x9,x0,-5 then a dependent sw: non-load producer, no stall.
    dec({12'hFFB, 5'd0, 3'b000, 5'd9, 7'b0010011}, 1'b0,
        ex(C_ADDI, 0, 0, 32'hFFFFFFFB, 5'd0, 5'd27, 5'd9));
    dec({7'd0, 5'd5, 5'd2, 3'b010, 5'b01000, 7'b0100011}, 1'b0,
        ex(C_SW, 32'h22, 32'hDEADBEEF, 32'd8, 5'd2, 5'd5, 5'd8));
    step(32'h0, 1'b0, 1'b0, 5'd0, 0, 1'b0, 1'b0, 1'b0, bub());

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2 chk("drain", {32'd0, 32'(exp_q.size())}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
